// File: rtl/lbp_linebuf.sv
// lbp_linebuf: streaming 3x3 Local Binary Pattern generator.
//   Reads a gray image once in raster order, keeps two line buffers plus a
//   3x3 window, and writes one LBP code per interior pixel. Optionally writes
//   zero codes to every border pixel afterwards, then raises finish.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   gray_ready                  image memory available (may drop any cycle)
//   gray_req, gray_addr         read request / raster address
//   gray_data                   read data, valid the cycle after gray_req
//   border_zero                 latched at frame start: 1 = zero-fill border
//   lbp_valid, lbp_addr, lbp_data  result write port (addr/data 0 when idle)
//   finish                      frame complete, held until reset
module lbp_linebuf #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int THR   = 0,
  parameter int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_ready,
  output logic             gray_req,
  output logic [AW-1:0]    gray_addr,
  input  logic [PIX_W-1:0] gray_data,
  input  logic             border_zero,
  output logic             lbp_valid,
  output logic [AW-1:0]    lbp_addr,
  output logic [7:0]       lbp_data,
  output logic             finish
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int PSW = (CW > RW) ? CW : RW;
  localparam int PW1 = PIX_W + 1;
  localparam logic [PIX_W:0]  THR_X     = PW1'(THR);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_FILL, S_DONE} state_t;

  state_t           state, state_next;
  logic             bz_latched;
  logic             d_vld;
  logic [AW-1:0]    d_addr;
  logic [1:0]       seg;
  logic [PSW-1:0]   pos;

  // Line buffers: lb0 holds row y-2, lb1 holds row y-1 for incoming row y.
  logic [PIX_W-1:0] lb0 [0:IMG_W-1];
  logic [PIX_W-1:0] lb1 [0:IMG_W-1];

  // Window columns x-2 (a_*) and x-1 (b_*); column x is the incoming n_*.
  logic [PIX_W-1:0] a_top, a_mid, a_bot, b_top, b_mid, b_bot;
  logic [PIX_W-1:0] n_top, n_mid, n_bot;

  logic [CW-1:0]    dx;
  logic [RW-1:0]    dy;
  logic             win_ok;
  logic [7:0]       code;
  logic [AW-1:0]    fill_addr;
  logic             fill_last_pos;

  // neighbor >= center + THR evaluated one bit wider so center+THR cannot wrap
  function automatic logic ge_thr(input logic [PIX_W-1:0] n, input logic [PIX_W-1:0] c);
    return {1'b0, n} >= ({1'b0, c} + THR_X);
  endfunction

  assign gray_req = (state == S_READ) && gray_ready;
  assign dx       = d_addr[CW-1:0];
  assign dy       = d_addr[AW-1:CW];
  assign n_top    = lb0[dx];
  assign n_mid    = lb1[dx];
  assign n_bot    = gray_data;
  // Columns x-2..x all belong to row dy only when dx >= 2, which excludes wraps.
  assign win_ok   = d_vld && (dx >= CW'(2)) && (dy >= RW'(2));

  assign code = {ge_thr(n_bot, b_mid), ge_thr(b_bot, b_mid), ge_thr(a_bot, b_mid),
                 ge_thr(n_mid, b_mid), ge_thr(a_mid, b_mid),
                 ge_thr(n_top, b_mid), ge_thr(b_top, b_mid), ge_thr(a_top, b_mid)};

  assign fill_last_pos = (seg[1] == 1'b0) ? (pos == PSW'(IMG_W - 1)) : (pos == PSW'(IMG_H - 1));

  // Border address: row 0, row H-1, column 0, column W-1.
  always_comb begin
    fill_addr = '0;
    case (seg)
      2'd0:    fill_addr = AW'(pos);
      2'd1:    fill_addr = AW'((IMG_H - 1) * IMG_W) + AW'(pos);
      2'd2:    fill_addr = AW'(pos) << CW;
      2'd3:    fill_addr = (AW'(pos) << CW) + AW'(IMG_W - 1);
      default: fill_addr = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (gray_ready) state_next = S_READ; else state_next = S_IDLE;
      S_READ:  if (gray_req && (gray_addr == LAST_ADDR)) state_next = S_DRAIN;
               else state_next = S_READ;
      // The final result is registered in the cycle d_vld is high; leave after that.
      S_DRAIN: if (!d_vld) state_next = bz_latched ? S_FILL : S_DONE;
               else state_next = S_DRAIN;
      S_FILL:  if ((seg == 2'd3) && fill_last_pos) state_next = S_DONE;
               else state_next = S_FILL;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, read address, capture tracking and border-fill counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gray_addr  <= '0;
      bz_latched <= 1'b0;
      d_vld      <= 1'b0;
      d_addr     <= '0;
      seg        <= 2'd0;
      pos        <= '0;
    end else begin
      state <= state_next;
      d_vld <= gray_req;
      if (state == S_IDLE && gray_ready) bz_latched <= border_zero;
      // Address wraps to 0 after the last pixel, which is also its DONE value.
      if (gray_req) begin
        d_addr    <= gray_addr;
        gray_addr <= gray_addr + AW'(1);
      end
      if (state == S_FILL) begin
        if (fill_last_pos) begin
          pos <= '0;
          seg <= seg + 2'd1;
        end else begin
          pos <= pos + PSW'(1);
        end
      end
    end
  end

  // Window shift on every captured sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_top <= '0; a_mid <= '0; a_bot <= '0;
      b_top <= '0; b_mid <= '0; b_bot <= '0;
    end else if (d_vld) begin
      a_top <= b_top; a_mid <= b_mid; a_bot <= b_bot;
      b_top <= n_top; b_mid <= n_mid; b_bot <= n_bot;
    end
  end

  // Line buffer storage; contents are never read before being written in a frame.
  always_ff @(posedge clk) begin
    if (d_vld) begin
      lb0[dx] <= lb1[dx];
      lb1[dx] <= gray_data;
    end
  end

  // Registered result port and finish flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= 8'h00;
      finish    <= 1'b0;
    end else begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= 8'h00;
      finish    <= (state == S_DONE);
      if (win_ok) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= d_addr - AW'(IMG_W + 1);
        lbp_data  <= code;
      end else if (state == S_FILL) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= fill_addr;
      end
    end
  end

endmodule

// File: tb/tb_lbp_linebuf.sv
// tb_lbp_linebuf: self-checking bench for lbp_linebuf on an 8x8 image.
//   Two instances (THR=0 and THR=1) share inputs; one is selected per vector.
//   Expected writes come from a software LBP model pushed into a queue and
//   popped as the selected DUT writes.
module tb_lbp_linebuf;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gray_ready = 1'b0;
  logic       border_zero = 1'b0;
  logic [7:0] gray_data = 8'h00;
  logic       req0, req1, v0, v1, f0, f1;
  logic [5:0] ga0, ga1, a0, a1;
  logic [7:0] d0, d1;

  lbp_linebuf #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THR(0)) dut0 (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(req0), .gray_addr(ga0),
    .gray_data(gray_data), .border_zero(border_zero), .lbp_valid(v0), .lbp_addr(a0),
    .lbp_data(d0), .finish(f0));
  lbp_linebuf #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THR(1)) dut1 (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(req1), .gray_addr(ga1),
    .gray_data(gray_data), .border_zero(border_zero), .lbp_valid(v1), .lbp_addr(a1),
    .lbp_data(d1), .finish(f1));

  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       lreq, lv, lf;
  logic [5:0] lga, la;
  logic [7:0] ld;
  assign lreq = sel ? req1 : req0;
  assign lga  = sel ? ga1  : ga0;
  assign lv   = sel ? v1   : v0;
  assign la   = sel ? a1   : a0;
  assign ld   = sel ? d1   : d0;
  assign lf   = sel ? f1   : f0;

  logic [7:0] img [0:N-1];
  int cyc = 0;
  int req_cyc [0:N-1];
  int req_cnt [0:N-1];
  logic clr = 1'b0;

  // image memory with one-cycle read latency, plus request bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lreq) gray_data <= img[lga];
    for (int i = 0; i < N; i++) begin
      if (clr) req_cnt[i] <= 0;
      else if (lreq && (int'(lga) == i)) begin
        req_cnt[i] <= req_cnt[i] + 1;
        req_cyc[i] <= cyc;
      end
    end
  end

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic       interior;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int writes = 0;
  logic mon_en = 1'b0;
  logic chk_code = 1'b0;
  logic [7:0] code_const = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every write popped against the model, idle port must read zero
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (lv) begin
        writes++;
        if (q.size() == 0) check("extra_write", 1, 0);
        else begin
          e = q.pop_front();
          check("lbp_addr", int'(la), int'(e.addr));
          check("lbp_data", int'(ld), int'(e.data));
          if (e.interior) begin
            check("latency", cyc - req_cyc[int'(e.addr) + W + 1], 2);
            if (chk_code) check("code_const", int'(ld), int'(code_const));
          end
        end
      end else begin
        check("idle_zero", int'({la, ld}), 0);
      end
    end
  end

  task automatic set_img(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       img[i] = 8'(i);
        1:       img[i] = 8'd50;
        2:       img[i] = 8'(($urandom % 4) * 64 + $urandom_range(0, 3));
        default: img[i] = 8'd255;
      endcase
    end
  endtask

  task automatic build_exp(input int thr, input logic bz);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    exp_t e;
    q.delete();
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        e.addr = 6'(r * W + c);
        e.interior = 1'b1;
        for (int k = 0; k < 8; k++)
          e.data[k] = (int'(img[(r + dr[k]) * W + c + dc[k]]) >= int'(img[r * W + c]) + thr);
        q.push_back(e);
      end
    if (bz) begin
      e.data = 8'h00;
      e.interior = 1'b0;
      for (int c = 0; c < W; c++) begin e.addr = 6'(c);               q.push_back(e); end
      for (int c = 0; c < W; c++) begin e.addr = 6'((H - 1) * W + c); q.push_back(e); end
      for (int r = 0; r < H; r++) begin e.addr = 6'(r * W);           q.push_back(e); end
      for (int r = 0; r < H; r++) begin e.addr = 6'(r * W + W - 1);   q.push_back(e); end
    end
  endtask

  // One frame: reset, model, run; abort_at>0 asserts reset when gray_addr reaches it.
  task automatic run_frame(input logic s, input int kind, input logic bz, input logic rmode,
                           input int exp_writes, input logic chk, input logic [7:0] cc,
                           input int abort_at);
    int bad;
    bit aborted;
    @(posedge clk); #1;
    reset = 1'b1; gray_ready = 1'b0; clr = 1'b1;
    sel = s; chk_code = chk; code_const = cc; border_zero = bz;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("reset_req_addr", int'({lreq, lga}), 0);
    check("reset_outputs", int'({lv, la, ld, lf}), 0);
    set_img(kind);
    build_exp(s ? 1 : 0, bz);
    writes = 0;
    clr = 1'b0;
    reset = 1'b0;
    aborted = 1'b0;
    for (int t = 0; t < 3000 && !lf && !aborted; t++) begin
      @(posedge clk); #1;
      gray_ready = (rmode && t > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (t == 10) border_zero = ~bz;
      if (abort_at > 0 && int'(lga) == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_req_addr", int'({lreq, lga}), 0);
        check("abort_outputs", int'({lv, la, ld, lf}), 0);
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check("finish", int'(lf), 1);
      check("writes", writes, exp_writes);
      check("queue_empty", q.size(), 0);
      bad = 0;
      for (int i = 0; i < N; i++) if (req_cnt[i] != 1) bad++;
      check("req_once", bad, 0);
      gray_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("done_hold", int'({lreq, lga, lv, lf}), 1);
    end
  endtask

  typedef struct {
    logic       s;
    int         kind;
    logic       bz;
    logic       rmode;
    int         exp_writes;
    logic       chk;
    logic [7:0] cc;
  } vec_t;
  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 0, 1'b0, 1'b0, 36, 1'b1, 8'hF0};  // ramp
    vecs[1] = '{1'b0, 0, 1'b1, 1'b0, 68, 1'b1, 8'hF0};  // ramp + border fill
    vecs[2] = '{1'b0, 1, 1'b0, 1'b0, 36, 1'b1, 8'hFF};  // constant, THR=0
    vecs[3] = '{1'b1, 1, 1'b0, 1'b0, 36, 1'b1, 8'h00};  // constant, THR=1
    vecs[4] = '{1'b1, 3, 1'b0, 1'b0, 36, 1'b1, 8'h00};  // center 255, THR=1
    vecs[5] = '{1'b0, 0, 1'b0, 1'b1, 36, 1'b1, 8'hF0};  // ramp, gray_ready toggling
    vecs[6] = '{1'b0, 2, 1'b1, 1'b1, 68, 1'b0, 8'h00};  // random, fill, toggling
    vecs[7] = '{1'b1, 2, 1'b0, 1'b0, 36, 1'b0, 8'h00};  // random, THR=1
    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].s, vecs[i].kind, vecs[i].bz, vecs[i].rmode,
                vecs[i].exp_writes, vecs[i].chk, vecs[i].cc, 0);
    // reset in the middle of a frame, then a clean rerun of the ramp
    run_frame(1'b0, 0, 1'b0, 1'b0, 36, 1'b1, 8'hF0, 40);
    repeat (3) @(posedge clk);
    run_frame(1'b0, 0, 1'b0, 1'b0, 36, 1'b1, 8'hF0, 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
